// File: rtl/mshr_merge.sv
// mshr_merge: miss status holding registers with secondary-miss merging.
// Tracks outstanding misses by address; repeat misses to a tracked line merge.
//
// Ports:
//   clk, clr          clock, synchronous active-high reset
//   pAddress          alloc/lookup address
//   ptcid_in          requester tag stored on a primary alloc
//   rd_or_sw_in       request type stored on a primary alloc
//   alloc             allocate or merge request this cycle
//   dAddress, dealloc release the entry matching dAddress
//   mshr_hit          a valid entry matches pAddress
//   mshr_full         every entry is valid
//   alloc_ack         alloc accepted this cycle
//   merged            accepted alloc merged into an existing entry
//   dealloc_hit       a valid entry matches dAddress
//   ptcid_out         stored tag of the dAddress entry (0 on no match)
//   rd_or_sw_out      stored type of the dAddress entry (0 on no match)
//   merge_cnt_out     secondary-miss count of the dAddress entry
//   occupancy         registered count of valid entries
module mshr_merge #(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 15,
  parameter int ID_W    = 7,
  parameter int MERGE_W = 2,
  parameter int OCC_W   = $clog2(ENTRIES) + 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  pAddress,
  input  logic [ID_W-1:0]    ptcid_in,
  input  logic               rd_or_sw_in,
  input  logic               alloc,
  input  logic [ADDR_W-1:0]  dAddress,
  input  logic               dealloc,
  output logic               mshr_hit,
  output logic               mshr_full,
  output logic               alloc_ack,
  output logic               merged,
  output logic               dealloc_hit,
  output logic [ID_W-1:0]    ptcid_out,
  output logic               rd_or_sw_out,
  output logic [MERGE_W-1:0] merge_cnt_out,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [MERGE_W-1:0] MAX_MERGE = '1;

  logic [ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0]  addr_q  [ENTRIES];
  logic [ID_W-1:0]    ptcid_q [ENTRIES];
  logic [ENTRIES-1:0] type_q;
  logic [MERGE_W-1:0] cnt_q   [ENTRIES];
  logic [OCC_W-1:0]   occ_q;

  logic [ENTRIES-1:0] p_match;
  logic [ENTRIES-1:0] d_match;
  logic [MERGE_W-1:0] p_cnt;
  logic [ID_W-1:0]    d_ptcid;
  logic               d_type;
  logic [MERGE_W-1:0] d_cnt;

  // Addresses are unique among valid entries, so the
  // match vectors are one-hot and an OR-mux suffices.
  always_comb begin
    p_match = '0;
    d_match = '0;
    p_cnt   = '0;
    d_ptcid = '0;
    d_type  = 1'b0;
    d_cnt   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      p_match[i] = valid_q[i] &&
                   (addr_q[i] == pAddress);
      d_match[i] = valid_q[i] &&
                   (addr_q[i] == dAddress);
      if (p_match[i]) p_cnt = p_cnt | cnt_q[i];
      if (d_match[i]) begin
        d_ptcid = d_ptcid | ptcid_q[i];
        d_type  = d_type  | type_q[i];
        d_cnt   = d_cnt   | cnt_q[i];
      end
    end
  end

  logic [IDX_W-1:0] free_idx;
  logic             free_found;

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign mshr_hit      = |p_match;
  assign mshr_full     = &valid_q;
  assign dealloc_hit   = |d_match;
  assign ptcid_out     = d_ptcid;
  assign rd_or_sw_out  = d_type;
  assign merge_cnt_out = d_cnt;
  assign occupancy     = occ_q;

  logic do_free;
  logic kill;
  logic go;
  logic sat;
  logic do_merge;
  logic do_prim;

  assign do_free = dealloc && dealloc_hit;
  // Releasing the very line being requested wins;
  // the alloc is refused rather than re-merged.
  assign kill = do_free && (pAddress == dAddress);
  assign go   = alloc && !kill;
  assign sat  = (p_cnt == MAX_MERGE);

  always_comb begin
    do_merge = 1'b0;
    do_prim  = 1'b0;
    unique case (1'b1)
      !go:                          ;
      go && mshr_hit && !sat:       do_merge = 1'b1;
      go && mshr_hit && sat:        ;
      go && !mshr_hit && mshr_full: ;
      go && !mshr_hit && !mshr_full: do_prim = 1'b1;
      default:                      ;
    endcase
  end

  assign alloc_ack = do_merge || do_prim;
  assign merged    = do_merge;

  // The free slot is always invalid, so it can never
  // collide with the entry being released.
  logic [ENTRIES-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (do_free) valid_d = valid_d & ~d_match;
    if (do_prim) valid_d[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < ENTRIES; i++)
        cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < ENTRIES; i++) begin
        if (do_prim && free_idx == IDX_W'(i))
          cnt_q[i] <= '0;
        else if (do_merge && p_match[i])
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      unique case ({do_prim, do_free})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!clr && do_prim) begin
      addr_q[free_idx]  <= pAddress;
      ptcid_q[free_idx] <= ptcid_in;
      type_q[free_idx]  <= rd_or_sw_in;
    end
  end

endmodule

// File: tb/tb_mshr_merge.sv
// tb_mshr_merge: self-checking bench for mshr_merge.
// Directed scenarios plus randomized traffic against a slot model.
module tb_mshr_merge;

  logic        clk = 1'b0;
  logic        clr;
  logic [14:0] pAddress;
  logic [6:0]  ptcid_in;
  logic        rd_or_sw_in;
  logic        alloc;
  logic [14:0] dAddress;
  logic        dealloc;
  logic        mshr_hit;
  logic        mshr_full;
  logic        alloc_ack;
  logic        merged;
  logic        dealloc_hit;
  logic [6:0]  ptcid_out;
  logic        rd_or_sw_out;
  logic [1:0]  merge_cnt_out;
  logic [3:0]  occupancy;

  mshr_merge dut (
    .clk(clk), .clr(clr),
    .pAddress(pAddress), .ptcid_in(ptcid_in),
    .rd_or_sw_in(rd_or_sw_in), .alloc(alloc),
    .dAddress(dAddress), .dealloc(dealloc),
    .mshr_hit(mshr_hit), .mshr_full(mshr_full),
    .alloc_ack(alloc_ack), .merged(merged),
    .dealloc_hit(dealloc_hit), .ptcid_out(ptcid_out),
    .rd_or_sw_out(rd_or_sw_out),
    .merge_cnt_out(merge_cnt_out),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: a set of slots, each a tracked miss line.
  bit          m_v [8];
  logic [14:0] m_a [8];
  logic [6:0]  m_id[8];
  bit          m_t [8];
  int          m_c [8];

  // Outputs sampled during the most recent step.
  logic s_ack, s_mrg, s_hit, s_full, s_dhit, s_type;
  logic [6:0] s_pid;
  logic [1:0] s_cnt;
  logic [3:0] s_occ;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  function automatic int find(logic [14:0] a);
    for (int i = 0; i < 8; i++)
      if (m_v[i] && m_a[i] == a) return i;
    return -1;
  endfunction

  function automatic int used();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_v[i]);
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++)
      if (!m_v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 0;
      m_c[i] = 0;
    end
  endtask

  task automatic step(bit c, bit al, logic [14:0] pa,
                      logic [6:0] id, bit ty, bit de,
                      logic [14:0] da);
    int ph, dh, fs;
    bit full, kill, e_ack, e_mrg;
    clr = c; alloc = al; pAddress = pa;
    ptcid_in = id; rd_or_sw_in = ty;
    dealloc = de; dAddress = da;
    #1;
    ph   = find(pa);
    dh   = find(da);
    full = (used() == 8);
    kill = al && de && dh >= 0 && pa == da;
    e_ack = 0;
    e_mrg = 0;
    if (al && !kill) begin
      if (ph >= 0) begin
        if (m_c[ph] < 3) begin
          e_ack = 1;
          e_mrg = 1;
        end
      end else if (!full) e_ack = 1;
    end
    chk("mshr_hit", mshr_hit, ph >= 0);
    chk("mshr_full", mshr_full, full);
    chk("alloc_ack", alloc_ack, e_ack);
    chk("merged", merged, e_mrg);
    chk("dealloc_hit", dealloc_hit, dh >= 0);
    chk("ptcid_out", ptcid_out,
        dh >= 0 ? 32'(m_id[dh]) : 0);
    chk("rd_or_sw_out", rd_or_sw_out,
        dh >= 0 ? 32'(m_t[dh]) : 0);
    chk("merge_cnt_out", merge_cnt_out,
        dh >= 0 ? m_c[dh] : 0);
    chk("occupancy", occupancy, used());
    s_ack = alloc_ack; s_mrg = merged;
    s_hit = mshr_hit; s_full = mshr_full;
    s_dhit = dealloc_hit; s_pid = ptcid_out;
    s_type = rd_or_sw_out; s_cnt = merge_cnt_out;
    s_occ = occupancy;
    @(posedge clk);
    if (c) model_clear();
    else begin
      fs = lowest_free();
      if (de && dh >= 0) m_v[dh] = 0;
      if (e_mrg) m_c[ph]++;
      else if (e_ack) begin
        m_v[fs] = 1; m_a[fs] = pa;
        m_id[fs] = id; m_t[fs] = ty; m_c[fs] = 0;
      end
    end
    #1;
  endtask

  task automatic idle(logic [14:0] pa, logic [14:0] da);
    step(0, 0, pa, 7'h0, 0, 0, da);
  endtask

  task automatic do_reset();
    step(1, 0, 15'h0, 7'h0, 0, 0, 15'h0);
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 15'(i * 'h1111), 7'(i * 'h11),
           bit'(i & 1), 0, 15'h0);
      chk("fill_ack", s_ack, 1);
    end
  endtask

  logic [14:0] pool [12];

  initial begin
    clr = 1; alloc = 0; dealloc = 0;
    pAddress = '0; dAddress = '0;
    ptcid_in = '0; rd_or_sw_in = 0;
    @(posedge clk);
    #1;
    model_clear();

    // Reset state
    idle(15'h0000, 15'h0000);
    chk("rst_occ", s_occ, 0);
    chk("rst_hit", s_hit, 0);
    chk("rst_full", s_full, 0);
    chk("rst_dhit", s_dhit, 0);
    chk("rst_pid", s_pid, 0);
    chk("rst_cnt", s_cnt, 0);

    // Fill, then overflow
    fill8();
    idle(15'h0ABC, 15'h0ABC);
    chk("full_occ", s_occ, 8);
    chk("full_flag", s_full, 1);
    step(0, 1, 15'h0ABC, 7'h5, 0, 0, 15'h0);
    chk("ovf_ack", s_ack, 0);
    idle(15'h0ABC, 15'h0);
    chk("ovf_occ", s_occ, 8);
    chk("ovf_hit", s_hit, 0);

    // Dealloc from full, realloc into freed slot
    step(0, 0, 15'h0, 7'h0, 0, 1, 15'h4444);
    chk("d4_hit", s_dhit, 1);
    chk("d4_pid", s_pid, 7'h44);
    idle(15'h0, 15'h0);
    chk("d4_occ", s_occ, 7);
    chk("d4_full", s_full, 0);
    step(0, 1, 15'h0ABC, 7'h3C, 1, 0, 15'h0);
    chk("re_ack", s_ack, 1);
    idle(15'h0ABC, 15'h0ABC);
    chk("re_hit", s_hit, 1);
    chk("re_full", s_full, 1);
    chk("re_pid", s_pid, 7'h3C);

    // Full + dealloc same cycle: full is pre-edge
    step(0, 1, 15'h0DEF, 7'h1, 0, 1, 15'h1111);
    chk("fd_ack", s_ack, 0);
    idle(15'h0DEF, 15'h0);
    chk("fd_occ", s_occ, 7);

    // Merging and saturation
    do_reset();
    step(0, 1, 15'h1234, 7'h2A, 1, 0, 15'h0);
    chk("m0_ack", s_ack, 1);
    chk("m0_mrg", s_mrg, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 15'h1234, 7'h7F, 0, 0, 15'h1234);
      chk("mk_mrg", s_mrg, 1);
      chk("mk_cnt_pre", s_cnt, k - 1);
    end
    step(0, 1, 15'h1234, 7'h7F, 0, 0, 15'h0);
    chk("sat_ack", s_ack, 0);
    chk("sat_mrg", s_mrg, 0);
    idle(15'h0, 15'h1234);
    chk("sat_cnt", s_cnt, 3);
    chk("sat_pid", s_pid, 7'h2A);
    chk("sat_type", s_type, 1);
    chk("sat_occ", s_occ, 1);

    // Same-cycle alloc/dealloc on one line
    step(0, 1, 15'h2222, 7'h22, 0, 0, 15'h0);
    step(0, 1, 15'h2222, 7'h22, 0, 1, 15'h2222);
    chk("kill_ack", s_ack, 0);
    chk("kill_dhit", s_dhit, 1);
    idle(15'h2222, 15'h0);
    chk("kill_hit", s_hit, 0);
    chk("kill_occ", s_occ, 1);

    // Different lines: both land, occupancy steady
    step(0, 1, 15'h3333, 7'h33, 0, 0, 15'h0);
    step(0, 1, 15'h5555, 7'h55, 1, 1, 15'h3333);
    chk("both_ack", s_ack, 1);
    idle(15'h5555, 15'h3333);
    chk("both_occ", s_occ, 2);
    chk("both_hit", s_hit, 1);
    chk("both_dhit", s_dhit, 0);

    // Absent dealloc
    step(0, 0, 15'h0, 7'h0, 0, 1, 15'h5A5A);
    chk("abs_dhit", s_dhit, 0);
    chk("abs_pid", s_pid, 0);
    chk("abs_cnt", s_cnt, 0);
    idle(15'h0, 15'h0);
    chk("abs_occ", s_occ, 2);

    // Reset mid-operation overrides an alloc
    do_reset();
    for (int i = 0; i < 5; i++)
      step(0, 1, 15'(i * 'h1111 + 'h10), 7'(i), 0, 0, 15'h0);
    step(1, 1, 15'h6000, 7'h60, 0, 0, 15'h0);
    idle(15'h6000, 15'h0);
    chk("clr_occ", s_occ, 0);
    chk("clr_new", s_hit, 0);
    for (int i = 0; i < 5; i++) begin
      idle(15'(i * 'h1111 + 'h10),
           15'(i * 'h1111 + 'h10));
      chk("clr_old", s_hit, 0);
      chk("clr_oldd", s_dhit, 0);
    end

    // Randomized traffic over a small address pool
    for (int i = 0; i < 12; i++)
      pool[i] = 15'((i * 'h0A31 + 7) & 'h7FFF);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 6,
           pool[$urandom_range(0, 11)],
           7'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 4,
           pool[$urandom_range(0, 11)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mshr_merge.md
MSHR_MERGE -- requirements
Module: mshr_merge

Interface
REQ-001 Parameter ENTRIES, default 8, number of miss entries; power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 15, physical address width.
REQ-003 Parameter ID_W, default 7, ptcid width.
REQ-004 Parameter MERGE_W, default 2, secondary-miss counter width; MAX_MERGE = 2^MERGE_W - 1.
REQ-005 Parameter OCC_W, default $clog2(ENTRIES)+1, occupancy width.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 clr  input  1  synchronous, active-high reset.
REQ-008 pAddress  input  ADDR_W  alloc/lookup address.
REQ-009 ptcid_in  input  ID_W  requester tag stored on primary alloc.
REQ-010 rd_or_sw_in  input  1  request type stored on primary alloc.
REQ-011 alloc  input  1  allocate/merge request this cycle.
REQ-012 dAddress  input  ADDR_W  dealloc address.
REQ-013 dealloc  input  1  release the entry matching dAddress this cycle.
REQ-014 mshr_hit  output  1  valid entry matches pAddress.
REQ-015 mshr_full  output  1  all entries valid.
REQ-016 alloc_ack  output  1  alloc accepted this cycle.
REQ-017 merged  output  1  accepted alloc merged into an existing entry.
REQ-018 dealloc_hit  output  1  valid entry matches dAddress.
REQ-019 ptcid_out  output  ID_W  stored ptcid of dAddress entry.
REQ-020 rd_or_sw_out  output  1  stored type of dAddress entry.
REQ-021 merge_cnt_out  output  MERGE_W  secondary-miss count of dAddress entry.
REQ-022 occupancy  output  OCC_W  registered number of valid entries.

Function
REQ-023 Each entry SHALL hold valid, addr, ptcid, rd_or_sw, merge_cnt.
REQ-024 mshr_hit, mshr_full, dealloc_hit, ptcid_out, rd_or_sw_out, merge_cnt_out, alloc_ack, merged SHALL be combinational from current (pre-edge) state and inputs; state changes take effect at the next rising edge.
REQ-025 With dealloc_hit=0, ptcid_out, rd_or_sw_out, merge_cnt_out SHALL be 0.
REQ-026 Alloc, hit, merge_cnt < MAX_MERGE: alloc_ack=1, merged=1; entry merge_cnt increments by 1 at edge; ptcid/rd_or_sw unchanged.
REQ-027 Alloc, hit, merge_cnt = MAX_MERGE: alloc_ack=0, merged=0, no state change (counter saturates, never wraps).
REQ-028 Alloc, miss, not full: alloc_ack=1, merged=0; lowest-index invalid entry written with pAddress, ptcid_in, rd_or_sw_in, merge_cnt=0, valid=1.
REQ-029 Alloc, miss, full: alloc_ack=0, no state change; mshr_full uses pre-edge state even if a dealloc occurs the same cycle.
REQ-030 Dealloc with dealloc_hit=1 SHALL clear that entry's valid at the edge; dealloc with no match SHALL change nothing.
REQ-031 Alloc and dealloc same cycle, pAddress = dAddress, entry valid: dealloc wins, alloc_ack=0, entry freed.
REQ-032 Alloc and dealloc same cycle, different addresses: both SHALL take effect at the same edge.
REQ-033 No two valid entries SHALL ever hold the same address.
REQ-034 occupancy SHALL equal +1 on primary alloc, -1 on dealloc, unchanged when both occur or on merge/reject; range 0..ENTRIES.
REQ-035 alloc_ack, merged SHALL be 0 whenever alloc=0.

Reset
REQ-036 clr=1 at a rising edge SHALL clear all valid bits and merge counters and set occupancy to 0, overriding alloc/dealloc that cycle.
REQ-037 After reset: mshr_hit=0, mshr_full=0, dealloc_hit=0, ptcid_out=0, rd_or_sw_out=0, merge_cnt_out=0, occupancy=0.
REQ-038 Reset mid-operation (entries valid) SHALL discard all entries with no residual hit.

Verification
REQ-039 Defaults; alloc 8 distinct addresses 0x0000..0x7777, ptcid 0x00..0x77 -> alloc_ack=1 each, occupancy 8, mshr_full=1; 9th miss 0x0ABC -> alloc_ack=0, occupancy stays 8.
REQ-040 Alloc 0x1234 three more times after primary -> merged=1, counts 1,2,3; 4th -> alloc_ack=0; dAddress=0x1234 -> merge_cnt_out=3.
REQ-041 Full MSHR; dAddress=0x4444 dealloc -> dealloc_hit=1, ptcid_out=0x44; next cycle occupancy 7, mshr_full=0; alloc 0x0ABC lands in entry 4.
REQ-042 Same-cycle alloc 0x2222 and dealloc 0x2222 -> alloc_ack=0, entry freed, mshr_hit=0 next cycle; different addresses -> occupancy unchanged, both effective.
REQ-043 Dealloc of absent 0x5A5A -> dealloc_hit=0, outputs 0, occupancy unchanged.
REQ-044 clr=1 with 5 valid entries and alloc=1 -> next cycle occupancy 0, mshr_hit=0 for all prior addresses.
